// File: rtl/alu_result_fifo.sv
// alu_result_fifo: show-ahead FIFO capturing every ALU result, with saturating overflow/drop statistics
// Ports:
//    i_clk, i_rst           clock, asynchronous active-high reset
//    i_valid, i_data        ALU result strobe and word
//    i_overflow             ALU overflow flag; also requests a push on its own
//    i_flush                synchronous flush of pointers and occupancy
//    i_ready                consumer ready
//    o_valid, o_data        head entry available and its data
//    o_overflow             overflow flag of the head entry
//    o_full, o_count        full flag and current occupancy
//    o_ovf_cnt, o_drop_cnt  saturating counts of accepted overflowed and dropped results
module alu_result_fifo #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   input  logic [DATA_W-1:0]        i_data,
   input  logic                     i_overflow,
   input  logic                     i_flush,
   input  logic                     i_ready,
   output logic                     o_valid,
   output logic [DATA_W-1:0]        o_data,
   output logic                     o_overflow,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic [CNT_W-1:0]         o_ovf_cnt,
   output logic [CNT_W-1:0]         o_drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [DATA_W:0]  mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] ovf_q, ovf_d, drop_q, drop_d;
   logic             push_req, pop, push, drop;
   assign o_valid    = cnt_q != '0;
   assign o_full     = cnt_q == CW'(DEPTH);
   assign o_data     = o_valid ? mem_q[rd_q][DATA_W-1:0] : '0;
   assign o_overflow = o_valid & mem_q[rd_q][DATA_W];
   assign o_count    = cnt_q;
   assign o_ovf_cnt  = ovf_q;
   assign o_drop_cnt = drop_q;
   always_comb begin
      // overflowed results arrive with i_valid low and must still be captured
      push_req = i_valid | i_overflow;
      pop      = o_valid & i_ready;
      // a pop on the same edge frees the slot, so a full FIFO still accepts
      push     = push_req & (~o_full | pop) & ~i_flush;
      drop     = push_req & o_full & ~pop & ~i_flush;
      wr_d     = i_flush ? '0 : wr_q + AW'(push);
      rd_d     = i_flush ? '0 : rd_q + AW'(pop);
      cnt_d    = i_flush ? '0 : cnt_q + CW'(push) - CW'(pop);
      ovf_d    = ovf_q + CNT_W'(push & i_overflow & ~&ovf_q);
      drop_d   = drop_q + CNT_W'(drop & ~&drop_q);
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         ovf_q  <= '0;
         drop_q <= '0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         drop_q <= drop_d;
      end
   end
   // storage needs no reset: it is only visible through o_valid-gated outputs
   always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_q] <= {i_overflow, i_data};
   end
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: table-driven and scoreboard checks of alu_result_fifo
module tb_alu_result_fifo;
   localparam int DW = 12;
   localparam int DEPTH = 8;
   localparam int CW = 8;
   logic clk = 0, rst = 1;
   logic valid = 0, ovf = 0, flush = 0, ready = 0;
   logic [DW-1:0] data = '0;
   logic o_valid, o_overflow, o_full;
   logic [DW-1:0] o_data;
   logic [$clog2(DEPTH):0] o_count;
   logic [CW-1:0] o_ovf_cnt, o_drop_cnt;
   int errors = 0, checks = 0;
   logic [DW:0] q[$];
   int m_ovf = 0, m_drop = 0;
   always #5 clk = ~clk;
   alu_result_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_overflow(ovf),
      .i_flush(flush), .i_ready(ready), .o_valid(o_valid), .o_data(o_data),
      .o_overflow(o_overflow), .o_full(o_full), .o_count(o_count),
      .o_ovf_cnt(o_ovf_cnt), .o_drop_cnt(o_drop_cnt));
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic v, input logic o, input logic [DW-1:0] d, input logic r, input logic f);
      valid = v;
      ovf = o;
      data = d;
      ready = r;
      flush = f;
   endtask
   // scoreboard: checks the head against the expected queue, then predicts the coming edge
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         m_ovf = 0;
         m_drop = 0;
      end else begin
         logic pop, preq;
         check("sb_valid", int'(o_valid), int'(q.size() != 0));
         check("sb_count", int'(o_count), q.size());
         check("sb_ovf_cnt", int'(o_ovf_cnt), m_ovf);
         check("sb_drop_cnt", int'(o_drop_cnt), m_drop);
         if (q.size() != 0) begin
            check("sb_data", int'(o_data), int'(q[0][DW-1:0]));
            check("sb_ovf", int'(o_overflow), int'(q[0][DW]));
         end
         if (flush) q.delete();
         else begin
            pop = q.size() != 0 && ready;
            preq = valid | ovf;
            if (preq && q.size() == DEPTH && !pop) m_drop = m_drop < 255 ? m_drop + 1 : 255;
            if (pop) void'(q.pop_front());
            if (preq && q.size() < DEPTH) begin
               q.push_back({ovf, data});
               if (ovf) m_ovf = m_ovf < 255 ? m_ovf + 1 : 255;
            end
         end
      end
   end
   typedef struct {
      logic v, o, r;
      logic [DW-1:0] d;
      int cnt, full, ovfc, drop;
   } vec_t;
   vec_t tv[26];
   initial begin
      tv[0] = '{1, 0, 1, 12'h005, 1, 0, 0, 0};
      tv[1] = '{1, 0, 1, 12'hFFE, 1, 0, 0, 0};
      tv[2] = '{1, 0, 1, 12'h7FF, 1, 0, 0, 0};
      tv[3] = '{0, 0, 1, 12'h000, 0, 0, 0, 0};
      tv[4] = '{0, 1, 0, 12'h800, 1, 0, 1, 0};
      tv[5] = '{0, 0, 0, 12'h123, 1, 0, 1, 0};
      tv[6] = '{0, 0, 1, 12'h000, 0, 0, 1, 0};
      for (int i = 7; i < 17; i++)
         tv[i] = '{1, 0, 0, 12'(i - 6), (i - 6 > 8) ? 8 : i - 6, int'(i - 6 >= 8), 1, (i - 6 > 8) ? i - 14 : 0};
      tv[17] = '{1, 0, 1, 12'h0AA, 8, 1, 1, 2};
      for (int i = 18; i < 26; i++) tv[i] = '{0, 0, 1, 12'h000, 25 - i, 0, 1, 2};
      #3;
      check("rst_valid", int'(o_valid), 0);
      check("rst_full", int'(o_full), 0);
      check("rst_count", int'(o_count), 0);
      check("rst_data", int'(o_data), 0);
      tick();
      tick();
      rst = 0;
      for (int i = 0; i < 26; i++) begin
         drive(tv[i].v, tv[i].o, tv[i].d, tv[i].r, 0);
         tick();
         check($sformatf("vec%0d_count", i), int'(o_count), tv[i].cnt);
         check($sformatf("vec%0d_full", i), int'(o_full), tv[i].full);
         check($sformatf("vec%0d_valid", i), int'(o_valid), int'(tv[i].cnt != 0));
         check($sformatf("vec%0d_ovfcnt", i), int'(o_ovf_cnt), tv[i].ovfc);
         check($sformatf("vec%0d_drop", i), int'(o_drop_cnt), tv[i].drop);
         if (i == 0) check("latency_data", int'(o_data), 12'h005);
         if (i == 4) check("ovf_head", int'(o_overflow), 1);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 12'(12'h100 + i), 0, 0);
         tick();
      end
      check("pre_flush_count", int'(o_count), 4);
      drive(1, 1, 12'h3C3, 1, 1);
      tick();
      check("flush_count", int'(o_count), 0);
      check("flush_valid", int'(o_valid), 0);
      check("flush_drop", int'(o_drop_cnt), 2);
      check("flush_ovfcnt", int'(o_ovf_cnt), 1);
      for (int i = 0; i < 8 + 300; i++) begin
         drive(1, 0, 12'(i), 0, 0);
         tick();
      end
      check("sat_drop", int'(o_drop_cnt), 255);
      check("sat_full", int'(o_full), 1);
      check("sat_count", int'(o_count), 8);
      drive(0, 0, 0, 0, 1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 12'(12'h0F0 + i), 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0);
      check("held_count", int'(o_count), 3);
      check("held_ovfcnt", int'(o_ovf_cnt), 4);
      #2 rst = 1;
      #1;
      check("async_valid", int'(o_valid), 0);
      check("async_count", int'(o_count), 0);
      check("async_ovfcnt", int'(o_ovf_cnt), 0);
      check("async_drop", int'(o_drop_cnt), 0);
      check("async_data", int'(o_data), 0);
      tick();
      rst = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle_valid", int'(o_valid), 0);
         check("idle_count", int'(o_count), 0);
         check("idle_full", int'(o_full), 0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the 12-bit signed ALU; captures every ALU result, including overflowed ones, into a small FIFO.
- The ALU has no backpressure input, so this block absorbs result bursts and presents them to a consumer via valid/ready handshake.
- Keeps saturating statistics of overflowed results and of results dropped while full.

Parameters:
DATA_W, 12, width of ALU result word
DEPTH, 8, FIFO entries; power of two, >= 2
CNT_W, 8, width of each statistics counter

Ports:
i_clk  input  1  clock
i_rst  input  1  asynchronous active-high reset
i_valid  input  1  ALU result-valid strobe
i_data  input  DATA_W  ALU result word
i_overflow  input  1  ALU overflow flag for the same cycle
i_flush  input  1  synchronous FIFO flush
i_ready  input  1  consumer ready
o_valid  output  1  head entry available
o_data  output  DATA_W  head entry data
o_overflow  output  1  head entry overflow flag
o_full  output  1  FIFO holds DEPTH entries
o_count  output  log2(DEPTH)+1  current occupancy
o_ovf_cnt  output  CNT_W  accepted entries with overflow flag, saturating
o_drop_cnt  output  CNT_W  results lost because FIFO full, saturating

Behaviour:
- One clock domain, i_clk rising edge. i_rst is asynchronous and active-high.
- While i_rst=1: pointers, o_count and both counters are 0; o_valid=0, o_full=0. o_data and o_overflow read 0; storage contents are don't-care.
- Reset asserted mid-operation discards all entries immediately, with no wait for a clock edge.
- Push request: push_req = i_valid | i_overflow. The ALU drops its valid on overflow, so an overflowed result arrives with i_valid=0, i_overflow=1 and must still be captured.
- Push stores {i_overflow, i_data} at the write pointer.
- Pop: pop = o_valid & i_ready. Advances the read pointer. Data is stable while o_valid=1 and i_ready=0.
- Output is show-ahead from registered storage, with no combinational path from i_* to o_data.
- Write-to-read latency: an entry pushed at edge N gives o_valid=1 after edge N, i.e. one cycle. An empty FIFO never passes a result through in the same cycle.
- o_valid = (count != 0). o_full = (count == DEPTH). o_count updates on the same edge as the push/pop.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are distinguished by the occupancy counter.
- Push and pop in the same cycle, non-empty and non-full: both happen, count unchanged.
- Push and pop in the same cycle while full: the pop frees a slot, the push is accepted, count stays DEPTH, no drop.
- Push while full without a pop: the entry is discarded and o_drop_cnt increments, saturating at 2^CNT_W-1. The stored contents are unchanged.
- o_ovf_cnt increments only when an entry with overflow=1 is actually accepted, saturating. Dropped overflowed results increment o_drop_cnt only.
- i_flush=1 on an edge: pointers and count go to 0. Any simultaneous push or pop is ignored and not counted as a drop. Statistics counters are retained; only i_rst clears them.
- Pop when empty is impossible because o_valid=0; i_ready is ignored.

Test Plan:
- Reset/idle: assert i_rst mid-stream with 3 entries held -> o_valid=0, o_count=0, o_ovf_cnt=0, o_drop_cnt=0 before the next edge. Release, idle 5 cycles -> outputs unchanged.
- Ordering and latency, i_ready=1: push 12'h005, 12'hFFE, 12'h7FF on consecutive cycles -> o_data shows 005, FFE, 7FF, each 1 cycle after its push. o_overflow=0 throughout, o_count returns to 0.
- Overflow capture: push with i_valid=0, i_overflow=1, i_data=12'h800 -> entry stored with o_overflow=1, o_ovf_cnt=1. A cycle with i_valid=0, i_overflow=0 pushes nothing.
- Full and drop (DEPTH=8), i_ready=0: push 10 values 1..10 -> o_full=1, o_count=8, o_drop_cnt=2. Then drain -> values 1..8 in order.
- Simultaneous push/pop at full: hold full, assert push (12'h0AA) and i_ready=1 for one cycle -> o_count stays 8, o_drop_cnt unchanged, 12'h0AA emerges last after draining.
- Flush and saturation: i_flush with 4 entries and a concurrent push -> o_count=0, o_drop_cnt unchanged. Then 300 drops with CNT_W=8 -> o_drop_cnt=255.
